// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch prefetch queue: FSM encoding,
// data widths and the {instruction, pcplus4} queue entry.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] instruction;
    logic [XLEN-1:0] pcplus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular queue of fetched {instruction, pcplus4} entries. Flush clears the
// pointers and count and takes priority over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output logic         valid,
  output logic         full,
  output fetch_entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             push_en;
  logic             pop_en;

  assign valid   = (count != '0);
  assign full    = (count == FULL_COUNT);
  assign head    = mem[rd_ptr];
  assign push_en = push && !full;
  assign pop_en  = pop && valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
      // Pointers wrap naturally because DEPTH is a power of two.
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues one outstanding memory read at a time,
// buffers returned words in fetch_fifo and presents the head to IF/ID.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            out_valid,
  output logic [ILEN-1:0] out_instruction,
  output logic [XLEN-1:0] out_pcplus4,
  output fetch_state_e    debug_state
);

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic            fifo_full;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Memory handshake: imem_req/imem_addr are held stable from issue until the
  // single-cycle imem_ack that carries imem_data; the ack ends the request.
  // Consumer handshake: the head transfers in any cycle with out_valid=1 and
  // stall=0.
  assign push       = (state == WAIT) && imem_ack && !redirect;
  assign pop        = out_valid && !stall;
  assign push_entry = '{instruction: imem_data, pcplus4: fetch_pc + PC_INCR};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
          end else if (!fifo_full) begin
            state     <= WAIT;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        WAIT: begin
          if (redirect) begin
            // An ack in the same cycle is already consumed, so nothing to drop.
            fetch_pc <= redirect_pc;
            imem_req <= 1'b0;
            state    <= imem_ack ? IDLE : DROP;
          end else if (imem_ack) begin
            fetch_pc <= fetch_pc + PC_INCR;
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end
        DROP: begin
          if (redirect) fetch_pc <= redirect_pc;
          if (imem_ack) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .valid     (out_valid),
    .full      (fifo_full),
    .head      (head)
  );

  assign out_instruction = head.instruction;
  assign out_pcplus4     = head.pcplus4;
  assign debug_state     = state;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, prefetch queue entries; power of two, >=2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  fetch address, valid while imem_req=1.
REQ-007 imem_ack  input  1  one-cycle pulse; imem_data valid in that cycle.
REQ-008 imem_data  input  32  instruction word returned by memory.
REQ-009 redirect  input  1  taken branch/jump from the MEM stage; flush and refetch.
REQ-010 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-011 stall  input  1  IF/ID register not writable (hazard unit); head is not consumed.
REQ-012 out_valid  output  1  head entry valid toward IF/ID.
REQ-013 out_instruction  output  32  head instruction word.
REQ-014 out_pcplus4  output  32  head fetch address + 4.

Function
REQ-015 The block holds fetch_pc and a DEPTH-entry circular queue of {instruction, pcplus4} with rd_ptr, wr_ptr, count (0..DEPTH).
REQ-016 The FSM has three states: IDLE, WAIT, DROP; at most one memory request is outstanding.
REQ-017 In IDLE with count<DEPTH and redirect=0, the block asserts imem_req with imem_addr=fetch_pc and enters WAIT next cycle.
REQ-018 In WAIT, imem_req and imem_addr are held stable until imem_ack=1.
REQ-019 On imem_ack in WAIT: push {imem_data, fetch_pc+4}; fetch_pc+=4 (mod 2^32); go to IDLE.
REQ-020 On redirect in WAIT without ack: go to DROP; fetch_pc=redirect_pc.
REQ-021 On redirect with ack in the same WAIT cycle: discard the response; fetch_pc=redirect_pc; go to IDLE.
REQ-022 In DROP, imem_req=0; on imem_ack, discard imem_data and go to IDLE; a further redirect only reloads fetch_pc.
REQ-023 On redirect in any state: count, rd_ptr, wr_ptr clear next cycle; out_valid=0 next cycle; redirect overrides push and pop.
REQ-024 out_valid=(count!=0); out_* come combinationally from the head entry; 1-cycle latency ack->out_valid when empty.
REQ-025 Pop occurs when out_valid=1 and stall=0; rd_ptr advances mod DEPTH.
REQ-026 Simultaneous push and pop leaves count unchanged; both pointers advance.
REQ-027 When full (count=DEPTH), no new request; push cannot overflow because a request is issued only when count<DEPTH.
REQ-028 When empty with stall=1, state is unchanged; out_valid stays 0.

Reset
REQ-029 While reset=0: state=IDLE, fetch_pc=RESET_PC, count=0, rd_ptr=wr_ptr=0, all storage=0, imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instruction=0, out_pcplus4=0.
REQ-030 Reset assertion mid-request abandons it; the first request after release is to RESET_PC; a late ack is ignored in IDLE.

Structure
REQ-031 Shared package fetch_pkg holds the state encoding (IDLE/WAIT/DROP), PC_INCR=4, and the 32-bit instruction/address widths.
REQ-032 Queue storage, pointers and count live in one sub-module fetch_fifo; the FSM and fetch_pc live in fetch_queue.

Verification
REQ-033 Reset release, memory acks 1 cycle after each req, stall=0 -> addresses 0,4,8,...; out_pcplus4 4,8,12 on consecutive valid cycles.
REQ-034 stall=1 held while acks continue -> after 4 pushes count=4, imem_req=0, head remains instruction@0 with out_pcplus4=4.
REQ-035 redirect=1, redirect_pc=32'h40 while in WAIT, ack 2 cycles later -> ack discarded, out_valid=0, next req addr=32'h40.
REQ-036 redirect and imem_ack in the same cycle with queue holding 2 entries -> queue empties, data dropped, next req addr=redirect_pc.
REQ-037 fetch_pc=32'hFFFF_FFFC acked -> out_pcplus4=0, next req addr=0.
REQ-038 reset=0 during WAIT, then released -> imem_req re-asserts with imem_addr=RESET_PC and out_valid=0.
